dest_sel_pipe: RTL and testbench
================================

Name: dest_sel_pipe

Overview:
- Parametrised successor to the 5-bit rt/rd destination-register mux.
- Three sources for the write destination:
  - rt field
  - rd field
  - a fixed link register, for jal-type writes
- Carries the selected destination and its write-valid bit through a STAGES-deep pipeline, supporting stall and flush.
- Sits between decode and write-back.
- Supplies the write-back address/enable and per-stage hazard match vectors for two source operands.

Parameters:
- ADDR_W, 5, register-address width in bits.
- STAGES, 3, number of pipeline stages tracked, indexed 0 (EX) to STAGES-1 (WB). Minimum 1.
- LINK_REG, 31, address selected when sel=2'b10. Must fit in ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in1  input  ADDR_W  rt field, IR[20:16] for ADDR_W=5.
- in2  input  ADDR_W  rd field, IR[15:11] for ADDR_W=5.
- sel  input  2  destination select: 00=in1, 01=in2, 10=LINK_REG, 11=in1.
- reg_write  input  1  decoded instruction writes a register.
- stall  input  1  freeze all stages.
- flush  input  1  kill the instruction entering stage 0.
- src_a  input  ADDR_W  decode-stage source operand A (rs).
- src_b  input  ADDR_W  decode-stage source operand B (rt).
- dest_address  output  ADDR_W  combinational selected destination (decode stage).
- stage_dest  output  STAGES*ADDR_W  flattened stage addresses; stage k occupies bits [k*ADDR_W +: ADDR_W].
- stage_valid  output  STAGES  per-stage write-valid.
- wb_dest  output  ADDR_W  equals stage STAGES-1 address.
- wb_we  output  1  equals stage_valid[STAGES-1].
- haz_a  output  STAGES  per-stage match against src_a.
- haz_b  output  STAGES  per-stage match against src_b.
- haz_any  output  1  OR of all bits of haz_a and haz_b.

Behaviour:
- Reset is synchronous and active-high on rst, sampled at the rising edge of clk. It has priority over stall and flush.
- Reset values:
  - all stage addresses = 0
  - stage_valid = 0
  - wb_dest = 0, wb_we = 0
  - haz_a = 0, haz_b = 0, haz_any = 0
  - dest_address remains combinational.
- dest_address is a zero-latency mux per the sel encoding above. sel=11 aliases to in1.
- Entry bit v0 = reg_write & ~flush & (dest_address != 0). Register 0 is never tracked as a write.
- Per edge, when not in reset:
  - stall=0, flush=0: stage0 <= {dest_address, v0}; stage k <= stage k-1 for k >= 1.
  - stall=0, flush=1: stage0 <= {dest_address, 0}; stages 1.. shift normally.
  - stall=1, flush=0: all stages hold.
  - stall=1, flush=1: stage0 valid cleared and address held; stages 1.. hold.
- Latency: a write selected in decode appears on wb_we/wb_dest exactly STAGES stall-free cycles later.
- STAGES=1: stage 0 is also the WB stage.
- Hazard: haz_a[k] = stage_valid[k] & (stage k address == src_a) & (src_a != 0); haz_b likewise for src_b. Outputs are combinational from the stage registers.
- stage_dest and wb_dest hold their last address when valid=0; consumers must qualify with valid.

Optional Feature:
- DEST_HAZARD_EN defined: hazard logic as specified above.
- DEST_HAZARD_EN undefined: haz_a, haz_b and haz_any are tied to 0 and no comparators are generated. Ports remain present and the pipeline is unchanged.

Test Plan:
- Defaults (ADDR_W=5, STAGES=3), no macro. rst=1 for 2 cycles -> stage_valid=3'b000, wb_we=0, wb_dest=0. in1=4, in2=2, sel=00 then 01 -> dest_address=4 then 2 with no clock edge.
- sel=10, reg_write=1, one cycle, stall=0 -> stage_valid = 001, 010, 100 on successive edges; wb_dest=31 and wb_we=1 on the 3rd edge, then wb_we=0.
- Issue dest 7 (sel=01, in2=7) with reg_write=1, then stall=1 for 2 cycles -> stage0 keeps 7/valid for the stall cycles; wb_we=1 at the 5th edge after issue.
- flush=1 with reg_write=1, in1=9, sel=00 -> stage0 valid=0 and wb_we never asserts for 9. Dest 0 with reg_write=1 -> never valid.
- DEST_HAZARD_EN defined, dest 5 issued, src_a=5, src_b=0 -> haz_a = 001, 010, 100 on successive cycles, haz_b=0, haz_any=1. src_a=0 with any stage holding 0 -> haz_a=0.
- rst asserted while stages 0 and 2 are valid -> stage_valid=000 and wb_we=0 the next cycle; no stale write.

Source files
------------

// File: rtl/dest_sel_pipe_if.sv
// Bundle for the destination-select pipeline: decode-side inputs
// (rt/rd fields, select, write enable, stall/flush, source operands)
// and pipeline-side outputs (decode destination, per-stage
// address/valid, write-back address/enable, hazard vectors).
//   master : decode/control side, drives the inputs, observes the outputs
//   slave  : dest_sel_pipe side
interface dest_sel_pipe_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned STAGES = 3
);
  logic [ADDR_W-1:0]        in1;
  logic [ADDR_W-1:0]        in2;
  logic [1:0]               sel;
  logic                     reg_write;
  logic                     stall;
  logic                     flush;
  logic [ADDR_W-1:0]        src_a;
  logic [ADDR_W-1:0]        src_b;
  logic [ADDR_W-1:0]        dest_address;
  logic [STAGES*ADDR_W-1:0] stage_dest;
  logic [STAGES-1:0]        stage_valid;
  logic [ADDR_W-1:0]        wb_dest;
  logic                     wb_we;
  logic [STAGES-1:0]        haz_a;
  logic [STAGES-1:0]        haz_b;
  logic                     haz_any;

  modport master (
    output in1, in2, sel, reg_write, stall, flush, src_a, src_b,
    input  dest_address, stage_dest, stage_valid, wb_dest, wb_we,
           haz_a, haz_b, haz_any
  );

  modport slave (
    input  in1, in2, sel, reg_write, stall, flush, src_a, src_b,
    output dest_address, stage_dest, stage_valid, wb_dest, wb_we,
           haz_a, haz_b, haz_any
  );
endinterface

// File: rtl/dest_sel_pipe.sv
// Destination-register select and tracking pipeline.
// Selects the write destination (rt, rd or the link register) in decode
// and carries it with its write-valid bit through STAGES pipeline stages
// (0 = EX .. STAGES-1 = WB), with stall and flush of the entering slot.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (priority over stall/flush)
//   bus  - dest_sel_pipe_if.slave: decode inputs, stage/WB outputs,
//          hazard match vectors against src_a/src_b
// Optional feature macro: DEST_HAZARD_EN. When defined, haz_a/haz_b/
// haz_any compare each valid stage address against the source operands;
// when undefined they are tied to zero and no comparators exist.
module dest_sel_pipe #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  dest_sel_pipe_if.slave    bus
);

  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [ADDR_W-1:0] addr_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [ADDR_W-1:0] dest_sel;
  logic              v0;

  always_comb begin
    dest_sel = bus.in1;
    case (bus.sel)
      2'b01:   dest_sel = bus.in2;
      2'b10:   dest_sel = LINK_ADDR;
      default: dest_sel = bus.in1;
    endcase
  end

  // Register 0 is hard-wired, so a write to it is never tracked.
  assign v0 = bus.reg_write & ~bus.flush & (dest_sel != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) addr_q[k] <= '0;
      valid_q <= '0;
    end else if (!bus.stall) begin
      addr_q[0]  <= dest_sel;
      valid_q[0] <= v0;
      for (int unsigned k = 1; k < STAGES; k++) begin
        addr_q[k]  <= addr_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end else if (bus.flush) begin
      // Stalled flush: kill the occupant of stage 0 but keep its address.
      valid_q[0] <= 1'b0;
    end
  end

  always_comb begin
    bus.stage_dest = '0;
    for (int unsigned k = 0; k < STAGES; k++)
      bus.stage_dest[k*ADDR_W +: ADDR_W] = addr_q[k];
  end

  assign bus.dest_address = dest_sel;
  assign bus.stage_valid  = valid_q;
  assign bus.wb_dest      = addr_q[STAGES-1];
  assign bus.wb_we        = valid_q[STAGES-1];

`ifdef DEST_HAZARD_EN
  always_comb begin
    bus.haz_a = '0;
    bus.haz_b = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      bus.haz_a[k] = valid_q[k] & (addr_q[k] == bus.src_a) & (bus.src_a != '0);
      bus.haz_b[k] = valid_q[k] & (addr_q[k] == bus.src_b) & (bus.src_b != '0);
    end
  end
  assign bus.haz_any = (|bus.haz_a) | (|bus.haz_b);
`else
  assign bus.haz_a   = '0;
  assign bus.haz_b   = '0;
  assign bus.haz_any = 1'b0;
`endif

endmodule

// File: tb/tb_dest_sel_pipe.sv
// Directed testbench for dest_sel_pipe with default parameters
// (ADDR_W=5, STAGES=3, LINK_REG=31). Hazard expectations follow the
// DEST_HAZARD_EN setting of the build.
module tb_dest_sel_pipe;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned STAGES = 3;
`ifdef DEST_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] exp3;
  logic       exp1;

  dest_sel_pipe_if #(.ADDR_W(ADDR_W), .STAGES(STAGES)) bus ();

  dest_sel_pipe #(.ADDR_W(ADDR_W), .STAGES(STAGES), .LINK_REG(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in1 = '0; bus.in2 = '0; bus.sel = 2'b00; bus.reg_write = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.src_a = '0; bus.src_b = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step(); step();
    checks++; if (bus.stage_valid !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b exp 000", bus.stage_valid); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", bus.wb_we); end
    checks++; if (bus.wb_dest !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d exp 0", bus.wb_dest); end
    checks++; if (bus.haz_any !== 1'b0) begin errors++; $display("FAIL reset_haz: got %b exp 0", bus.haz_any); end
    rst = 1'b0;
  endtask

  task automatic test_mux();
    bus.in1 = 5'd4; bus.in2 = 5'd2; bus.sel = 2'b00; #1;
    checks++; if (bus.dest_address !== 5'd4) begin errors++; $display("FAIL mux_00: got %0d exp 4", bus.dest_address); end
    bus.sel = 2'b01; #1;
    checks++; if (bus.dest_address !== 5'd2) begin errors++; $display("FAIL mux_01: got %0d exp 2", bus.dest_address); end
    bus.sel = 2'b10; #1;
    checks++; if (bus.dest_address !== 5'd31) begin errors++; $display("FAIL mux_10: got %0d exp 31", bus.dest_address); end
    bus.sel = 2'b11; #1;
    checks++; if (bus.dest_address !== 5'd4) begin errors++; $display("FAIL mux_11: got %0d exp 4", bus.dest_address); end
  endtask

  task automatic test_link();
    idle();
    bus.sel = 2'b10; bus.reg_write = 1'b1;
    step();
    checks++; if (bus.stage_valid !== 3'b001) begin errors++; $display("FAIL link_v1: got %b exp 001", bus.stage_valid); end
    checks++; if (bus.stage_dest[4:0] !== 5'd31) begin errors++; $display("FAIL link_a0: got %0d exp 31", bus.stage_dest[4:0]); end
    bus.reg_write = 1'b0;
    step();
    checks++; if (bus.stage_valid !== 3'b010) begin errors++; $display("FAIL link_v2: got %b exp 010", bus.stage_valid); end
    step();
    checks++; if (bus.stage_valid !== 3'b100) begin errors++; $display("FAIL link_v3: got %b exp 100", bus.stage_valid); end
    checks++; if (bus.wb_we !== 1'b1) begin errors++; $display("FAIL link_we: got %b exp 1", bus.wb_we); end
    checks++; if (bus.wb_dest !== 5'd31) begin errors++; $display("FAIL link_wbd: got %0d exp 31", bus.wb_dest); end
    step();
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL link_we_off: got %b exp 0", bus.wb_we); end
  endtask

  task automatic test_stall();
    idle();
    bus.sel = 2'b01; bus.in2 = 5'd7; bus.reg_write = 1'b1;
    step();
    checks++; if (bus.stage_valid !== 3'b001) begin errors++; $display("FAIL stall_issue: got %b exp 001", bus.stage_valid); end
    bus.reg_write = 1'b0; bus.in2 = 5'd12; bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.stage_valid !== 3'b001) begin errors++; $display("FAIL stall_hold_v%0d: got %b exp 001", i, bus.stage_valid); end
      checks++; if (bus.stage_dest[4:0] !== 5'd7) begin errors++; $display("FAIL stall_hold_a%0d: got %0d exp 7", i, bus.stage_dest[4:0]); end
    end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.stage_valid !== 3'b010) begin errors++; $display("FAIL stall_resume: got %b exp 010", bus.stage_valid); end
    step();
    checks++; if (bus.wb_we !== 1'b1) begin errors++; $display("FAIL stall_we: got %b exp 1", bus.wb_we); end
    checks++; if (bus.wb_dest !== 5'd7) begin errors++; $display("FAIL stall_wbd: got %0d exp 7", bus.wb_dest); end
    step();
  endtask

  task automatic test_flush();
    idle();
    bus.in1 = 5'd9; bus.sel = 2'b00; bus.reg_write = 1'b1; bus.flush = 1'b1;
    step();
    checks++; if (bus.stage_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_v0: got %b exp 0", bus.stage_valid[0]); end
    checks++; if (bus.stage_dest[4:0] !== 5'd9) begin errors++; $display("FAIL flush_a0: got %0d exp 9", bus.stage_dest[4:0]); end
    bus.flush = 1'b0; bus.reg_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL flush_we%0d: got %b exp 0", i, bus.wb_we); end
    end
    // stall + flush kills stage 0 in place
    bus.in1 = 5'd3; bus.reg_write = 1'b1;
    step();
    bus.in1 = 5'd20; bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    checks++; if (bus.stage_valid !== 3'b000) begin errors++; $display("FAIL sflush_v: got %b exp 000", bus.stage_valid); end
    checks++; if (bus.stage_dest[4:0] !== 5'd3) begin errors++; $display("FAIL sflush_a0: got %0d exp 3", bus.stage_dest[4:0]); end
    // destination 0 is never tracked
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in1 = 5'd0; bus.reg_write = 1'b1;
    step();
    checks++; if (bus.stage_valid[0] !== 1'b0) begin errors++; $display("FAIL r0_v0: got %b exp 0", bus.stage_valid[0]); end
    bus.reg_write = 1'b0;
    step(); step();
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL r0_we: got %b exp 0", bus.wb_we); end
  endtask

  task automatic test_hazard();
    idle();
    step(); step(); step();
    bus.in2 = 5'd5; bus.sel = 2'b01; bus.reg_write = 1'b1; bus.src_a = 5'd5; bus.src_b = 5'd0;
    step();
    bus.reg_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp3 = HZ ? (3'b001 << i) : 3'b000;
      exp1 = HZ;
      checks++; if (bus.haz_a !== exp3) begin errors++; $display("FAIL haz_a%0d: got %b exp %b", i, bus.haz_a, exp3); end
      checks++; if (bus.haz_b !== 3'b000) begin errors++; $display("FAIL haz_b%0d: got %b exp 000", i, bus.haz_b); end
      checks++; if (bus.haz_any !== exp1) begin errors++; $display("FAIL haz_any%0d: got %b exp %b", i, bus.haz_any, exp1); end
      step();
    end
    checks++; if (bus.haz_any !== 1'b0) begin errors++; $display("FAIL haz_drain: got %b exp 0", bus.haz_any); end
    // zero operand against a zero destination never matches
    bus.in1 = 5'd0; bus.sel = 2'b00; bus.reg_write = 1'b1; bus.src_a = 5'd0;
    step();
    checks++; if (bus.haz_a !== 3'b000) begin errors++; $display("FAIL haz_zero: got %b exp 000", bus.haz_a); end
  endtask

  task automatic test_reset_midflight();
    idle();
    bus.in2 = 5'd6; bus.sel = 2'b01; bus.reg_write = 1'b1;
    step();
    bus.reg_write = 1'b0;
    step();
    bus.in2 = 5'd8; bus.reg_write = 1'b1;
    step();
    checks++; if (bus.stage_valid !== 3'b101) begin errors++; $display("FAIL mid_pre: got %b exp 101", bus.stage_valid); end
    rst = 1'b1; bus.stall = 1'b1;
    step();
    checks++; if (bus.stage_valid !== 3'b000) begin errors++; $display("FAIL mid_rst_v: got %b exp 000", bus.stage_valid); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b exp 0", bus.wb_we); end
    rst = 1'b0; bus.stall = 1'b0; bus.reg_write = 1'b0;
    step();
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL mid_stale: got %b exp 0", bus.wb_we); end
  endtask

  initial begin
    test_reset();
    test_mux();
    test_link();
    test_stall();
    test_flush();
    test_hazard();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1);
  end
endmodule
